key_buffer_stream: RTL and testbench
====================================

// Module: key_buffer_stream
// PURPOSE
//   Next-generation evaluation-key buffer for key switching: DP independent BRAM banks,
//   DEEP_BANKS at full depth 2^ADDR_WIDTH, the rest at half depth.
//   Each bank has a per-bank read address and a registered read path.
//   Writes arrive as a valid/ready stream of full-width beats under a load FSM
//   that generates addresses. Sits between the DMA key loader and the NTT/MAC datapath.
// PARAMETERS
//   DP          256  number of banks (lanes)
//   DATA_WIDTH  54   word width per bank
//   ADDR_WIDTH  11   address width; full-depth banks hold 2^ADDR_WIDTH words
//   DEEP_BANKS  128  banks 0..DEEP_BANKS-1 are full depth; banks DEEP_BANKS..DP-1 hold 2^(ADDR_WIDTH-1)
//   RD_LAT      2    read latency in cycles; legal values are 1 or 2
// PORTS
//   clk         in   1                 clock
//   rst_n       in   1                 asynchronous reset, active low
//   load_start  in   1                 start a load; sampled only in IDLE
//   load_base   in   ADDR_WIDTH        first write address
//   load_len    in   ADDR_WIDTH+1      number of beats, 0..2^ADDR_WIDTH
//   load_busy   out  1                 FSM is in LOAD
//   load_done   out  1                 one-cycle pulse when a load completes
//   wr_valid    in   1                 write beat valid
//   wr_ready    out  1                 equal to load_busy
//   wr_data     in   DP*DATA_WIDTH     bank i data is [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_en       in   1                 read request, all banks
//   rd_addr     in   DP*ADDR_WIDTH     bank i address is [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data     out  DP*DATA_WIDTH     read data
//   rd_valid    out  1                 rd_data valid, asserted RD_LAT cycles after rd_en
//   oob_err     out  1                 sticky out-of-range flag; cleared by an accepted load_start
// BEHAVIOUR
//   Reset: FSM goes to IDLE; load_busy, load_done, rd_valid and oob_err = 0; rd_data = 0.
//     Bank contents are not reset. Asserting reset mid-load aborts the load;
//     beats already written stay in memory.
//   FSM states and transitions:
//     IDLE -> LOAD on load_start. The FSM latches base and len, sets cnt = 0 and clears oob_err.
//       If len == 0, IDLE -> DONE instead, with no writes.
//     LOAD: a beat is accepted when wr_valid && wr_ready. It writes every bank at
//       (base + cnt) mod 2^ADDR_WIDTH, so the address wraps, then cnt++.
//       When the len-th beat is accepted, LOAD -> DONE.
//     DONE: load_done = 1 for exactly one cycle, then the FSM returns to IDLE.
//       A load_start presented in DONE is ignored.
//     load_start in LOAD is ignored.
//   Half-depth banks: on an address with MSB = 1, a write is dropped for those banks only
//     and sets oob_err. A read of such an address returns 0 for those banks and sets oob_err.
//   Reads: these are independent of the FSM and allowed in every state, every cycle, fully pipelined.
//     RD_LAT = 1: BRAM output goes directly to rd_data.
//     RD_LAT = 2: an extra output register is added.
//     rd_data holds its last value when rd_valid = 0.
//   Read/write collision: a read and an accepted write in the same cycle on the same bank
//     and address return the OLD word (read-first), unless the bypass feature is enabled.
// CONFIGURATION
//   KEYBUF_BYPASS_EN defined: per-bank forwarding; on a same-cycle same-address collision,
//     rd_data carries the new wr_data word at the same RD_LAT. Forwarding does not apply
//     to dropped out-of-range writes.
//   KEYBUF_BYPASS_EN undefined: read-first as above; no forwarding logic.
// TESTING
//   1. load_base=0, load_len=4, wr_valid held high with beats D0..D3, then rd_en with all
//      rd_addr=2 -> load_done pulses 1 cycle after beat 4 is accepted; rd_data=D2 with
//      rd_valid exactly RD_LAT cycles after rd_en.
//   2. load_base=2046, load_len=3 (ADDR_WIDTH=11), wr_valid toggling 1,0,1,0,1 -> writes
//      land at 2046, 2047 and 0; exactly 3 accepted beats; oob_err=1 because half-depth banks see MSB=1.
//   3. load_len=0 -> load_done is asserted on the cycle after load_start; wr_ready never rises;
//      memory unchanged.
//   4. Read the same bank at address 5 in the same cycle a beat writes 5 with new value N
//      (old value O) -> rd_data=O without KEYBUF_BYPASS_EN, N with it.
//   5. Read with bank 0 addr=1500 and bank DP-1 addr=1500 -> bank 0 returns its stored word,
//      bank DP-1 returns 0, oob_err=1; the next accepted load_start clears oob_err.
//   6. Assert rst_n low after 2 of 6 beats -> load_busy=0 and rd_valid=0 immediately; a
//      read of address base+1 after release returns beat 1.

Source files
------------

// File: rtl/key_buffer_stream_if.sv
// Key-buffer bus bundle: load control, write beat stream and per-bank read port.
// The DMA/datapath side takes the master modport, the buffer takes the slave modport.
interface key_buffer_stream_if #(
  parameter int unsigned DP         = 256,
  parameter int unsigned DATA_WIDTH = 54,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                       load_start;
  logic [ADDR_WIDTH-1:0]      load_base;
  logic [ADDR_WIDTH:0]        load_len;
  logic                       load_busy;
  logic                       load_done;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [DP*DATA_WIDTH-1:0]   wr_data;
  logic                       rd_en;
  logic [DP*ADDR_WIDTH-1:0]   rd_addr;
  logic [DP*DATA_WIDTH-1:0]   rd_data;
  logic                       rd_valid;
  logic                       oob_err;

  modport master (
    output load_start, load_base, load_len, wr_valid, wr_data, rd_en, rd_addr,
    input  load_busy, load_done, wr_ready, rd_data, rd_valid, oob_err
  );

  modport slave (
    input  load_start, load_base, load_len, wr_valid, wr_data, rd_en, rd_addr,
    output load_busy, load_done, wr_ready, rd_data, rd_valid, oob_err
  );
endinterface

// File: rtl/key_buffer_stream.sv
// Banked evaluation-key buffer: streamed full-width loads, independent per-bank reads.
// Optional macro KEYBUF_BYPASS_EN forwards a same-cycle write word to a colliding read.
module key_buffer_stream #(
  parameter int unsigned DP         = 256,
  parameter int unsigned DATA_WIDTH = 54,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEEP_BANKS = 128,
  parameter int unsigned RD_LAT     = 2
) (
  input logic                clk,
  input logic                rst_n,
  key_buffer_stream_if.slave kb_if
);

  localparam int unsigned LEN_W      = ADDR_WIDTH + 1;
  localparam int unsigned FULL_DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned HALF_DEPTH = 2 ** (ADDR_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic                   oob_q;
  logic                   rv1_q;

  logic                   start_acc_c;
  logic                   wr_fire_c;
  logic                   last_beat_c;
  logic [ADDR_WIDTH-1:0]  wr_addr_c;
  logic                   wr_oob_c;
  logic                   rd_oob_c;
  logic                   rd_valid_c;
  logic [DATA_WIDTH-1:0]  rd_word_c [DP];
  logic [DP*DATA_WIDTH-1:0] rd_data_c;

  assign wr_fire_c   = kb_if.wr_valid && busy_q;
  assign last_beat_c = (cnt_q + LEN_W'(1)) == len_q;
  assign wr_addr_c   = base_q + cnt_q[ADDR_WIDTH-1:0];

  // Load FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Load FSM next state; load_start only counts in IDLE
  always_comb begin
    state_d     = state_q;
    start_acc_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kb_if.load_start) begin
          start_acc_c = 1'b1;
          state_d     = (kb_if.load_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wr_fire_c && last_beat_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  // Load descriptor and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (start_acc_c) begin
      base_q <= kb_if.load_base;
      len_q  <= kb_if.load_len;
      cnt_q  <= '0;
    end else if (wr_fire_c) begin
      cnt_q  <= cnt_q + LEN_W'(1);
    end
  end

  assign wr_oob_c = wr_fire_c && wr_addr_c[ADDR_WIDTH-1] && (DEEP_BANKS < DP);

  // Any half-depth bank asked for an upper-half address
  always_comb begin
    rd_oob_c = 1'b0;
    for (int unsigned b = DEEP_BANKS; b < DP; b++) begin
      if (kb_if.rd_en && kb_if.rd_addr[b*ADDR_WIDTH + ADDR_WIDTH - 1]) rd_oob_c = 1'b1;
    end
  end

  // Sticky range error; a fresh error outranks the clear from a new load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_q <= 1'b0;
    end else if (wr_oob_c || rd_oob_c) begin
      oob_q <= 1'b1;
    end else if (start_acc_c) begin
      oob_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv1_q <= 1'b0;
    else        rv1_q <= kb_if.rd_en;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic rv2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rv2_q <= 1'b0;
      else        rv2_q <= rv1_q;
    end
    assign rd_valid_c = rv2_q;
  end else begin : g_lat1
    assign rd_valid_c = rv1_q;
  end

  for (genvar b = 0; b < DP; b++) begin : g_bank
    localparam bit          DEEP  = (b < DEEP_BANKS);
    localparam int unsigned DEPTH = DEEP ? FULL_DEPTH : HALF_DEPTH;
    localparam int unsigned IDX_W = DEEP ? ADDR_WIDTH : ADDR_WIDTH - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] bram_q;
    logic [ADDR_WIDTH-1:0] ra_c;
    logic [DATA_WIDTH-1:0] wd_c;
    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic                  we_c;

    assign ra_c    = kb_if.rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd_c    = kb_if.wr_data[b*DATA_WIDTH +: DATA_WIDTH];
    assign wr_ok_c = DEEP || !wr_addr_c[ADDR_WIDTH-1];
    assign rd_ok_c = DEEP || !ra_c[ADDR_WIDTH-1];
    assign we_c    = wr_fire_c && wr_ok_c;

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
      if (we_c) mem[IDX_W'(wr_addr_c)] <= wd_c;
    end

    // BRAM read register; non-blocking read of mem gives read-first on collision
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bram_q <= '0;
      end else if (kb_if.rd_en) begin
        if (!rd_ok_c) begin
          bram_q <= '0;
`ifdef KEYBUF_BYPASS_EN
        end else if (we_c && (ra_c == wr_addr_c)) begin
          bram_q <= wd_c;
`endif
        end else begin
          bram_q <= mem[IDX_W'(ra_c)];
        end
      end
    end

    if (RD_LAT == 2) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     out_q <= '0;
        else if (rv1_q) out_q <= bram_q;
      end
      assign rd_word_c[b] = out_q;
    end else begin : g_noreg
      assign rd_word_c[b] = bram_q;
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int unsigned b = 0; b < DP; b++) begin
      rd_data_c[b*DATA_WIDTH +: DATA_WIDTH] = rd_word_c[b];
    end
  end

  assign kb_if.load_busy = busy_q;
  assign kb_if.wr_ready  = busy_q;
  assign kb_if.load_done = done_q;
  assign kb_if.oob_err   = oob_q;
  assign kb_if.rd_valid  = rd_valid_c;
  assign kb_if.rd_data   = rd_data_c;

endmodule

// File: tb/tb_key_buffer_stream.sv
// Bench for key_buffer_stream: directed scenarios plus random loads/reads against an
// address-indexed beat model. Define KEYBUF_BYPASS_EN for both bench and RTL together.
module tb_key_buffer_stream;

  localparam int unsigned DP     = 256;
  localparam int unsigned DW     = 54;
  localparam int unsigned AW     = 11;
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned DEEP   = 128;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned NW     = DP * DW;
  localparam int unsigned DEPTH  = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_buffer_stream_if #(.DP(DP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) kb ();

  key_buffer_stream #(
    .DP(DP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEEP_BANKS(DEEP), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kb_if (kb)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: full beat last written to each address, plus the expected sticky flag
  logic [NW-1:0] mdl [int];
  int            wq[$];
  bit            exp_oob;
  int            raddr [DP];
  logic [NW-1:0] exp_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] rand_beat();
    logic [NW-1:0] v;
    for (int b = 0; b < int'(DP); b++) v[b*DW +: DW] = DW'({$urandom(), $urandom()});
    return v;
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [NW-1:0] v, input int b);
    return v[b*DW +: DW];
  endfunction

  // Half-depth banks only hold the lower half of the address space
  function automatic bit out_of_range(input int b, input int a);
    return (b >= int'(DEEP)) && (a >= int'(DEPTH / 2));
  endfunction

  function automatic logic [NW-1:0] expect_read();
    logic [NW-1:0] v;
    logic [NW-1:0] line;
    v = '0;
    for (int b = 0; b < int'(DP); b++) begin
      if (!out_of_range(b, raddr[b]) && mdl.exists(raddr[b])) begin
        line = mdl[raddr[b]];
        v[b*DW +: DW] = line[b*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic set_all_addr(input int a);
    for (int b = 0; b < int'(DP); b++) raddr[b] = a;
  endtask

  task automatic check_words(input string tag, input logic [NW-1:0] exp);
    check({tag, "_b0"},    64'(word_of(kb.rd_data, 0)),        64'(word_of(exp, 0)));
    check({tag, "_bdeep"}, 64'(word_of(kb.rd_data, DEEP - 1)), 64'(word_of(exp, DEEP - 1)));
    check({tag, "_bhalf"}, 64'(word_of(kb.rd_data, DEEP)),     64'(word_of(exp, DEEP)));
    check({tag, "_blast"}, 64'(word_of(kb.rd_data, DP - 1)),   64'(word_of(exp, DP - 1)));
    check({tag, "_all"},   64'(kb.rd_data == exp),             64'(1));
  endtask

  // Called at a negedge: drive one read request and record its expected result
  task automatic rd_issue();
    exp_rd = expect_read();
    for (int b = 0; b < int'(DP); b++) begin
      if (out_of_range(b, raddr[b])) exp_oob = 1'b1;
      kb.rd_addr[b*AW +: AW] = AW'(raddr[b]);
    end
    kb.rd_en = 1'b1;
  endtask

  task automatic rd_collect(input string tag);
    @(negedge clk);
    kb.rd_en    = 1'b0;
    kb.wr_valid = 1'b0;
    for (int k = 1; k < int'(RD_LAT); k++) begin
      check({tag, "_early"}, 64'(kb.rd_valid), 64'(0));
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(kb.rd_valid), 64'(1));
    check_words(tag, exp_rd);
    check({tag, "_oob"}, 64'(kb.oob_err), 64'(exp_oob));
    @(negedge clk);
    check({tag, "_vlow"}, 64'(kb.rd_valid), 64'(0));
    check({tag, "_hold"}, 64'(kb.rd_data == exp_rd), 64'(1));
  endtask

  task automatic do_read(input string tag);
    rd_issue();
    rd_collect(tag);
  endtask

  // mode 0: valid always high, 1: toggling starting high, 2: random
  task automatic do_load(input string tag, input int base, input int len, input int mode);
    int cnt   = 0;
    int guard = 0;
    bit tog   = 1'b1;
    bit v;
    int a;
    logic [NW-1:0] beat;
    kb.load_start = 1'b1;
    kb.load_base  = AW'(base);
    kb.load_len   = LW'(len);
    exp_oob       = 1'b0;
    @(negedge clk);
    kb.load_start = 1'b0;
    if (len == 0) begin
      check({tag, "_done"}, 64'(kb.load_done), 64'(1));
      check({tag, "_rdy"},  64'(kb.wr_ready),  64'(0));
      @(negedge clk);
      check({tag, "_done_end"}, 64'(kb.load_done), 64'(0));
      check({tag, "_rdy_end"},  64'(kb.wr_ready),  64'(0));
      return;
    end
    check({tag, "_rdy"}, 64'(kb.wr_ready), 64'(1));
    while (cnt < len && guard < 20 * len + 50) begin
      check({tag, "_busy"}, 64'(kb.load_busy), 64'(1));
      check({tag, "_nodone"}, 64'(kb.load_done), 64'(0));
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'(($urandom() >> 3) & 1);
      tog  = !tog;
      beat = rand_beat();
      kb.wr_valid = v;
      kb.wr_data  = beat;
      if (v) begin
        a = (base + cnt) % int'(DEPTH);
        if (!mdl.exists(a)) wq.push_back(a);
        mdl[a] = beat;
        if (a >= int'(DEPTH / 2)) exp_oob = 1'b1;
        cnt++;
      end
      guard++;
      @(negedge clk);
    end
    kb.wr_valid = 1'b0;
    check({tag, "_done"}, 64'(kb.load_done), 64'(1));
    check({tag, "_idle"}, 64'(kb.load_busy), 64'(0));
    check({tag, "_oob"},  64'(kb.oob_err),   64'(exp_oob));
    @(negedge clk);
    check({tag, "_done_end"}, 64'(kb.load_done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] beat_o, beat_n, beat1, exp_a, exp_b;
    kb.load_start = 1'b0;
    kb.load_base  = '0;
    kb.load_len   = '0;
    kb.wr_valid   = 1'b0;
    kb.wr_data    = '0;
    kb.rd_en      = 1'b0;
    kb.rd_addr    = '0;
    exp_oob       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy",  64'(kb.load_busy), 64'(0));
    check("rst_done",  64'(kb.load_done), 64'(0));
    check("rst_valid", 64'(kb.rd_valid),  64'(0));
    check("rst_oob",   64'(kb.oob_err),   64'(0));
    check("rst_data",  64'(kb.rd_data == '0), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic four-beat load and read back
    do_load("t1", 0, 4, 0);
    set_all_addr(2);
    do_read("t1_rd");

    // Wrapping load with a gappy stream
    do_load("t2", 2046, 3, 1);
    for (int b = 0; b < int'(DP); b++) raddr[b] = (b % 3 == 0) ? 2046 : (b % 3 == 1) ? 2047 : 0;
    do_read("t2_rd");

    // Zero-length load leaves memory alone
    do_load("t3", 2, 0, 0);
    set_all_addr(2);
    do_read("t3_rd");

    // Same-cycle read and write of address 5
    do_load("t4_pre", 5, 1, 0);
    beat_o = mdl[5];
    kb.load_start = 1'b1;
    kb.load_base  = AW'(5);
    kb.load_len   = LW'(1);
    exp_oob       = 1'b0;
    @(negedge clk);
    kb.load_start = 1'b0;
    check("t4_busy", 64'(kb.load_busy), 64'(1));
    beat_n      = rand_beat();
    kb.wr_valid = 1'b1;
    kb.wr_data  = beat_n;
    set_all_addr(5);
    rd_issue();
    check("t4_old_model", 64'(exp_rd == beat_o), 64'(1));
`ifdef KEYBUF_BYPASS_EN
    exp_rd = beat_n;
`endif
    mdl[5] = beat_n;
    rd_collect("t4_coll");
    do_read("t4_after");

    // Out-of-range read on half-depth banks, then cleared by the next load
    do_load("t5_pre", 1500, 2, 0);
    do_load("t5_clr", 0, 1, 0);
    set_all_addr(1500);
    do_read("t5_rd");
    check("t5_blast_zero", 64'(word_of(kb.rd_data, DP - 1)), 64'(0));
    do_load("t5_clr2", 3, 2, 0);

    // Reset in the middle of a six-beat load
    kb.load_start = 1'b1;
    kb.load_base  = AW'(100);
    kb.load_len   = LW'(6);
    exp_oob       = 1'b0;
    @(negedge clk);
    kb.load_start = 1'b0;
    check("t6_busy", 64'(kb.load_busy), 64'(1));
    beat_o = rand_beat();
    kb.wr_valid = 1'b1;
    kb.wr_data  = beat_o;
    if (!mdl.exists(100)) wq.push_back(100);
    mdl[100] = beat_o;
    set_all_addr(100);
    for (int b = 0; b < int'(DP); b++) kb.rd_addr[b*AW +: AW] = AW'(raddr[b]);
    kb.rd_en = 1'b1;
    @(negedge clk);
    beat1 = rand_beat();
    kb.wr_data = beat1;
    if (!mdl.exists(101)) wq.push_back(101);
    mdl[101] = beat1;
    @(negedge clk);
    check("t6_busy_pre", 64'(kb.load_busy), 64'(1));
    check("t6_valid_pre", 64'(kb.rd_valid), 64'(1));
    kb.wr_valid = 1'b0;
    kb.rd_en    = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("t6_busy_rst",  64'(kb.load_busy), 64'(0));
    check("t6_valid_rst", 64'(kb.rd_valid),  64'(0));
    check("t6_data_rst",  64'(kb.rd_data == '0), 64'(1));
    exp_oob = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle", 64'(kb.load_busy), 64'(0));
    set_all_addr(101);
    do_read("t6_rd");

    // Back-to-back reads of different addresses
    set_all_addr(2);
    rd_issue();
    exp_a = exp_rd;
    for (int cyc = 1; cyc <= int'(RD_LAT) + 1; cyc++) begin
      @(negedge clk);
      if (cyc == int'(RD_LAT)) begin
        check("pipe_a_valid", 64'(kb.rd_valid), 64'(1));
        check("pipe_a_data",  64'(kb.rd_data == exp_a), 64'(1));
      end
      if (cyc == int'(RD_LAT) + 1) begin
        check("pipe_b_valid", 64'(kb.rd_valid), 64'(1));
        check("pipe_b_data",  64'(kb.rd_data == exp_b), 64'(1));
      end
      if (cyc == 1) begin
        set_all_addr(101);
        rd_issue();
        exp_b = exp_rd;
      end else begin
        kb.rd_en = 1'b0;
      end
    end
    @(negedge clk);

    // Random loads and scattered per-bank reads
    for (int it = 0; it < 6; it++) begin
      do_load("rnd_ld", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 16)), 2);
      for (int r = 0; r < 3; r++) begin
        for (int b = 0; b < int'(DP); b++) raddr[b] = wq[$urandom_range(0, wq.size() - 1)];
        do_read("rnd_rd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
